imem_boot_loader: RTL and testbench

- Upstream boot stage for IMem: receives a byte stream from a host link and assembles 32-bit little-endian instruction words.
- Writes each word into IMem through its write port, then asserts done_load_inst.
- Holds RV64IF_top in reset until loading completes; replaces file-based preloading, so the core starts only after a complete, valid image.

---
 rtl/imem_boot_loader_if.sv | 42 ++++
 rtl/imem_boot_loader.sv | 119 +++++++++++
 tb/tb_imem_boot_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, IMem write port and boot status of the IMem boot loader.
// master = host/system side, slave = loader side.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 64
);
  logic [7:0]            in_byte;
  logic                  in_byte_valid;
  logic                  out_byte_ready;
  logic [ADDR_WIDTH-1:0] out_wr_addr;
  logic [31:0]           out_wr_data;
  logic                  out_wr_en;
  logic [31:0]           out_word_count;
  logic                  out_done_load_inst;
  logic                  out_err;
  logic                  out_core_Rst_N;

  modport master (
    output in_byte,
    output in_byte_valid,
    input  out_byte_ready,
    input  out_wr_addr,
    input  out_wr_data,
    input  out_wr_en,
    input  out_word_count,
    input  out_done_load_inst,
    input  out_err,
    input  out_core_Rst_N
  );

  modport slave (
    input  in_byte,
    input  in_byte_valid,
    output out_byte_ready,
    output out_wr_addr,
    output out_wr_data,
    output out_wr_en,
    output out_word_count,
    output out_done_load_inst,
    output out_err,
    output out_core_Rst_N
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Assembles a little-endian byte stream (4-byte count header + payload words)
// into 32-bit IMem writes and holds the core in reset until the image is complete.
module imem_boot_loader #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MAX_WORDS  = 1024
) (
  input  logic              in_Clk,
  input  logic              Rst_N,
  imem_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t                state_reg;
  logic [1:0]            byte_idx_reg;
  logic [31:0]           word_idx_reg;
  logic [31:0]           shift_reg;
  logic                  wr_en_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic [31:0]           wr_data_reg;
  logic [31:0]           word_count_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic                  core_rst_n_reg;

  logic                  byte_ready;
  logic                  accept;
  logic [31:0]           assembled;
  logic [31:0]           word_idx_next;
  logic [ADDR_WIDTH-1:0] wr_addr_next;

  // Ready is a pure function of state so it never loops back through valid.
  assign byte_ready    = (state_reg == HDR) || (state_reg == LOAD);
  assign accept        = bus.in_byte_valid && byte_ready;
  assign assembled     = {bus.in_byte, shift_reg[31:8]};
  assign word_idx_next = word_idx_reg + 32'd1;
  assign wr_addr_next  = BASE_ADDR + ADDR_WIDTH'({word_idx_reg, 2'b00});

  always_ff @(posedge in_Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_reg      <= HDR;
      byte_idx_reg   <= 2'd0;
      word_idx_reg   <= 32'd0;
      shift_reg      <= 32'd0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= BASE_ADDR;
      wr_data_reg    <= 32'd0;
      word_count_reg <= 32'd0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      core_rst_n_reg <= 1'b0;
    end else begin
      case (state_reg)
        HDR: begin
          if (accept) begin
            shift_reg    <= assembled;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              word_count_reg <= assembled;
              if (assembled == 32'd0) begin
                state_reg      <= DONE;
                done_reg       <= 1'b1;
                core_rst_n_reg <= 1'b1;
              end else if (assembled > 32'(MAX_WORDS)) begin
                state_reg <= ERR;
                err_reg   <= 1'b1;
              end else begin
                state_reg <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          if (accept) begin
            shift_reg    <= assembled;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              state_reg   <= WRITE;
              wr_en_reg   <= 1'b1;
              wr_data_reg <= assembled;
              wr_addr_reg <= wr_addr_next;
            end
          end
        end
        WRITE: begin
          wr_en_reg    <= 1'b0;
          word_idx_reg <= word_idx_next;
          if (word_idx_next == word_count_reg) begin
            state_reg      <= DONE;
            done_reg       <= 1'b1;
            core_rst_n_reg <= 1'b1;
          end else begin
            state_reg <= LOAD;
          end
        end
        DONE: state_reg <= DONE;
        ERR:  state_reg <= ERR;
        default: state_reg <= HDR;
      endcase
    end
  end

  assign bus.out_byte_ready     = byte_ready;
  assign bus.out_wr_en          = wr_en_reg;
  assign bus.out_wr_addr        = wr_addr_reg;
  assign bus.out_wr_data        = wr_data_reg;
  assign bus.out_word_count     = word_count_reg;
  assign bus.out_done_load_inst = done_reg;
  assign bus.out_err            = err_reg;
  assign bus.out_core_Rst_N     = core_rst_n_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two loaders (base 0 and base 0x10570) share one byte
// stream; expected IMem writes go to per-loader scoreboards and are checked on wr_en.
module tb_imem_boot_loader;

  localparam logic [63:0] BASE0 = 64'h0;
  localparam logic [63:0] BASE1 = 64'h10570;

  typedef struct {
    logic [31:0] n;
    logic [31:0] w [3];
    int          bub;
    bit          err;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst_n;

  imem_boot_loader_if #(.ADDR_WIDTH(64)) bus0 ();
  imem_boot_loader_if #(.ADDR_WIDTH(64)) bus1 ();

  assign bus1.in_byte       = bus0.in_byte;
  assign bus1.in_byte_valid = bus0.in_byte_valid;

  imem_boot_loader #(.ADDR_WIDTH(64), .BASE_ADDR(BASE0), .MAX_WORDS(1024)) dut0 (
    .in_Clk (clk),
    .Rst_N  (rst_n),
    .bus    (bus0)
  );

  imem_boot_loader #(.ADDR_WIDTH(64), .BASE_ADDR(BASE1), .MAX_WORDS(1024)) dut1 (
    .in_Clk (clk),
    .Rst_N  (rst_n),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  pass_cnt  = 0;
  int  total_cnt = 0;
  int  acc_cnt   = 0;
  int  wr_cnt0   = 0;
  int  wr_cnt1   = 0;
  int  sent      = 0;
  wr_t sb0 [$];
  wr_t sb1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard side: compare every write strobe against the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus0.in_byte_valid && bus0.out_byte_ready) acc_cnt++;
      if (bus0.out_wr_en === 1'b1) begin
        wr_t e;
        wr_cnt0++;
        check("dut0_write_expected", 64'(sb0.size() != 0), 64'd1);
        if (sb0.size() != 0) begin
          e = sb0.pop_front();
          check("dut0_wr_addr", bus0.out_wr_addr, e.addr);
          check("dut0_wr_data", 64'(bus0.out_wr_data), 64'(e.data));
        end
        $display("dut0 write addr=%h data=%h", bus0.out_wr_addr, bus0.out_wr_data);
      end
      if (bus1.out_wr_en === 1'b1) begin
        wr_t e;
        wr_cnt1++;
        check("dut1_write_expected", 64'(sb1.size() != 0), 64'd1);
        if (sb1.size() != 0) begin
          e = sb1.pop_front();
          check("dut1_wr_addr", bus1.out_wr_addr, e.addr);
          check("dut1_wr_data", 64'(bus1.out_wr_data), 64'(e.data));
        end
        $display("dut1 write addr=%h data=%h", bus1.out_wr_addr, bus1.out_wr_data);
      end
    end
  end

  task automatic do_reset();
    bus0.in_byte       = 8'h00;
    bus0.in_byte_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en",      bus0.out_wr_en, 0);
    check("rst_wr_addr0",   bus0.out_wr_addr, BASE0);
    check("rst_wr_addr1",   bus1.out_wr_addr, BASE1);
    check("rst_wr_data",    bus0.out_wr_data, 0);
    check("rst_word_count", bus0.out_word_count, 0);
    check("rst_done",       bus0.out_done_load_inst, 0);
    check("rst_err",        bus0.out_err, 0);
    check("rst_core_rst_n", bus0.out_core_Rst_N, 0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", bus0.out_byte_ready, 1);
    acc_cnt = 0;
    wr_cnt0 = 0;
    wr_cnt1 = 0;
    sent    = 0;
    sb0.delete();
    sb1.delete();
  endtask

  // Present one byte (after optional bubbles) and hold it until an edge with ready.
  task automatic send_byte(input logic [7:0] b, input int bub, output bit ok);
    bit r;
    ok = 1'b0;
    if (bub > 0) begin
      int nb = $urandom_range(0, bub);
      for (int i = 0; i < nb; i++) begin
        bus0.in_byte_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus0.in_byte       = b;
    bus0.in_byte_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      r = bus0.out_byte_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) sent++;
    check("byte_accepted", 64'(ok), 64'd1);
  endtask

  task automatic send_image(input vec_t v);
    bit  ok;
    wr_t e;
    for (int k = 0; k < 4; k++) send_byte(v.n[8*k +: 8], v.bub, ok);
    if (v.err) begin
      bus0.in_byte_valid = 1'b0;
      check("err_flag",       bus0.out_err, 1);
      check("err_ready",      bus0.out_byte_ready, 0);
      check("err_core_rst_n", bus0.out_core_Rst_N, 0);
      check("err_done",       bus0.out_done_load_inst, 0);
      bus0.in_byte       = 8'hAA;
      bus0.in_byte_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("err_ready_held", bus0.out_byte_ready, 0);
    end else if (v.n == 32'd0) begin
      bus0.in_byte_valid = 1'b0;
      check("zero_done",       bus0.out_done_load_inst, 1);
      check("zero_core_rst_n", bus0.out_core_Rst_N, 1);
      check("zero_ready",      bus0.out_byte_ready, 0);
    end else begin
      for (int w = 0; w < int'(v.n); w++) begin
        for (int k = 0; k < 4; k++) begin
          if (k == 3) begin
            e.data = v.w[w];
            e.addr = BASE0 + 64'(4 * w);
            sb0.push_back(e);
            e.addr = BASE1 + 64'(4 * w);
            sb1.push_back(e);
          end
          send_byte(v.w[w][8*k +: 8], v.bub, ok);
        end
        check("wr_en_after_4th", bus0.out_wr_en, 1);
        check("write_ready_low", bus0.out_byte_ready, 0);
        if (w == int'(v.n) - 1) begin
          bus0.in_byte_valid = 1'b0;
          check("not_done_in_write", bus0.out_done_load_inst, 0);
          check("core_held_in_write", bus0.out_core_Rst_N, 0);
          @(posedge clk);
          #1;
          check("done_after_last", bus0.out_done_load_inst, 1);
          check("core_rst_n_after_last", bus0.out_core_Rst_N, 1);
          check("wr_en_drops", bus0.out_wr_en, 0);
        end
      end
    end
    bus0.in_byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("write_count0", 64'(wr_cnt0), v.err ? 64'd0 : 64'(v.n));
    check("write_count1", 64'(wr_cnt1), v.err ? 64'd0 : 64'(v.n));
    check("sb0_drained",  64'(sb0.size()), 64'd0);
    check("sb1_drained",  64'(sb1.size()), 64'd0);
    check("word_count0",  bus0.out_word_count, 64'(v.n));
    check("word_count1",  bus1.out_word_count, 64'(v.n));
    check("bytes_accepted", 64'(acc_cnt), 64'(sent));
    check("final_done", bus0.out_done_load_inst, v.err ? 64'd0 : 64'd1);
    check("final_err",  bus0.out_err, v.err ? 64'd1 : 64'd0);
    $display("image n=%0d bub=%0d done=%0b err=%0b writes=%0d",
             v.n, v.bub, bus0.out_done_load_inst, bus0.out_err, wr_cnt0);
  endtask

  vec_t vecs [6];

  initial begin
    bit   ok;
    vec_t v;
    rst_n              = 1'b0;
    bus0.in_byte       = 8'h00;
    bus0.in_byte_valid = 1'b0;

    vecs[0] = '{n: 32'd2,     w: '{32'h00000013, 32'h00A00093, 32'h0}, bub: 0, err: 1'b0};
    vecs[1] = '{n: 32'd0,     w: '{32'h0, 32'h0, 32'h0},               bub: 0, err: 1'b0};
    vecs[2] = '{n: 32'h401,   w: '{32'h0, 32'h0, 32'h0},               bub: 0, err: 1'b1};
    vecs[3] = '{n: 32'd2,     w: '{32'h00000013, 32'h00A00093, 32'h0}, bub: 3, err: 1'b0};
    vecs[4] = '{n: 32'd3,     w: '{32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE}, bub: 1, err: 1'b0};
    vecs[5] = '{n: 32'd1,     w: '{32'hDEADBEEF, 32'h0, 32'h0},        bub: 0, err: 1'b0};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      send_image(vecs[i]);
    end

    // Reset in the middle of word 1, then a fresh one-word image.
    do_reset();
    send_byte(8'h02, 0, ok);
    send_byte(8'h00, 0, ok);
    send_byte(8'h00, 0, ok);
    send_byte(8'h00, 0, ok);
    send_byte(8'h13, 0, ok);
    send_byte(8'h00, 0, ok);
    bus0.in_byte_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en",      bus0.out_wr_en, 0);
    check("midrst_core_rst_n", bus0.out_core_Rst_N, 0);
    check("midrst_word_count", bus0.out_word_count, 0);
    check("midrst_ready",      bus0.out_byte_ready, 1);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    acc_cnt = 0;
    sent    = 0;
    wr_cnt0 = 0;
    wr_cnt1 = 0;
    v = '{n: 32'd1, w: '{32'hDEADBEEF, 32'h0, 32'h0}, bub: 0, err: 1'b0};
    send_image(v);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
